// File: rtl/alu_pkg.sv
// alu_pkg: shared state encodings and constants for the ALU-side divider
package alu_pkg;
  localparam int DEF_WIDTH = 4;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  // quotient reported for a zero divisor, sliced to the operand width
  localparam logic [63:0] QUO_DZ = '1;
endpackage

// File: rtl/seq_divider_if.sv
// seq_divider_if: start/done handshake and operand/result bus of the divider
interface seq_divider_if #(parameter int WIDTH = alu_pkg::DEF_WIDTH);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             busy;
  logic             done;
  logic             div_zero;
  modport master (output start, a, b, input q, r, busy, done, div_zero);
  modport slave  (input start, a, b, output q, r, busy, done, div_zero);
endinterface

// File: rtl/div_trial_sub.sv
// div_trial_sub: (WIDTH+1)-bit trial subtraction rem_shift - b via add-complement
module div_trial_sub #(parameter int WIDTH = 4) (
  input  logic [WIDTH:0]   rem_shift_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             neg_o
);
  logic [WIDTH:0] full;
  // inverted zero-extended divisor plus carry-in of one forms the two's complement
  assign full   = rem_shift_i + ~{1'b0, b_i} + 1'b1;
  assign diff_o = full[WIDTH-1:0];
  assign neg_o  = full[WIDTH];
endmodule

// File: rtl/seq_divider.sv
// seq_divider: sequential unsigned restoring divider, one quotient bit per clock
module seq_divider import alu_pkg::*; #(parameter int WIDTH = DEF_WIDTH) (
  input  logic         clk,
  input  logic         rst_n,
  seq_divider_if.slave dif
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d, dvs_q, dvs_d, rem_q, rem_d, quo_q, quo_d;
  logic [WIDTH-1:0] q_q, q_d, r_q, r_d, diff;
  logic             dz_q, dz_d, neg, accept;
  logic [WIDTH:0]   rem_shift;
  assign rem_shift = {rem_q, dvd_q[WIDTH-1]};
  assign accept    = dif.start && (state_q == S_IDLE || state_q == S_DONE);
  div_trial_sub #(.WIDTH(WIDTH)) u_sub (
    .rem_shift_i(rem_shift),
    .b_i        (dvs_q),
    .diff_o     (diff),
    .neg_o      (neg)
  );
  // next state: iterate in RUN, accept operands in IDLE/DONE, results load only on entry to DONE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    if (state_q == S_RUN) begin
      rem_d = neg ? rem_shift[WIDTH-1:0] : diff;
      quo_d = {quo_q[WIDTH-2:0], ~neg};
      dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
      cnt_d = cnt_q - 1'b1;
      if (cnt_d == '0) begin
        state_d = S_DONE;
        q_d     = quo_d;
        r_d     = rem_d;
        dz_d    = 1'b0;
      end
    end else if (accept) begin
      dvd_d   = dif.a;
      dvs_d   = dif.b;
      rem_d   = '0;
      quo_d   = '0;
      state_d = (dif.b == '0) ? S_DONE : S_RUN;
      cnt_d   = CW'(WIDTH);
      if (dif.b == '0) begin
        q_d  = QUO_DZ[WIDTH-1:0];
        r_d  = dif.a;
        dz_d = 1'b1;
      end
    end else begin
      state_d = S_IDLE;
    end
  end
  // state and datapath registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
    end
  end
  assign dif.q        = q_q;
  assign dif.r        = r_q;
  assign dif.div_zero = dz_q;
  assign dif.busy     = state_q == S_RUN;
  assign dif.done     = state_q == S_DONE;
endmodule
